// File: rtl/mem_dma_master.sv
// Block-operation initiator for the data memory port: fill, copy, or 16-bit checksum of a word range.
// Define MEM_DMA_BOUNDS_CHECK_EN to reject commands whose ranges run past MEMORY_SIZE.
module mem_dma_master #(
  parameter int MEMORY_SIZE = 100,
  parameter int LEN_W       = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_val,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      mem_A,
  output logic [31:0]      mem_WD,
  output logic             mem_WE,
  input  logic [31:0]      mem_RD,
  output logic [15:0]      checksum
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic [1:0] {M_FILL = 2'b00, M_COPY = 2'b01, M_CSUM = 2'b10, M_ILL = 2'b11} mode_t;

`ifdef MEM_DMA_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif
  localparam logic [32:0] MEM_LIMIT = 33'(MEMORY_SIZE);

  state_t           state, state_d;
  mode_t            mode_q, mode_in;
  logic [31:0]      src_q, dst_q, fill_q, data_q, data_d;
  logic [LEN_W-1:0] len_q, idx, idx_d, idx_inc;
  logic [15:0]      acc, acc_d, checksum_q;
  logic             err_q, err_d, load_cmd, load_csum, last, range_err;
  logic [32:0]      src_end, dst_end;

  assign mode_in = mode_t'(mode);
  assign idx_inc = idx + 1'b1;
  assign last    = (idx_inc == len_q);

  // 33-bit sums so a range that wraps the 32-bit address space is still flagged.
  assign src_end   = {1'b0, src} + 33'(len);
  assign dst_end   = {1'b0, dst} + 33'(len);
  assign range_err = BOUNDS_EN &&
                     ((((mode_in == M_FILL) || (mode_in == M_COPY)) && (dst_end > MEM_LIMIT)) ||
                      (((mode_in == M_COPY) || (mode_in == M_CSUM)) && (src_end > MEM_LIMIT)));

  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    acc_d     = acc;
    data_d    = data_q;
    err_d     = err_q;
    load_cmd  = 1'b0;
    load_csum = 1'b0;
    mem_A     = '0;
    mem_WD    = '0;
    mem_WE    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_cmd = 1'b1;
          err_d    = 1'b0;
          idx_d    = '0;
          acc_d    = '0;
          if (mode_in == M_ILL || range_err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (len == '0) begin
            state_d = DONE;
          end else begin
            state_d = (mode_in == M_FILL) ? WRITE : READ;
          end
          load_csum = (state_d == DONE) && (mode_in == M_CSUM);
        end
      end
      READ: begin
        mem_A = src_q + 32'(idx);
        if (mode_q == M_CSUM) begin
          acc_d = acc + mem_RD[15:0] + mem_RD[31:16];
          idx_d = idx_inc;
          if (last) begin
            state_d   = DONE;
            load_csum = 1'b1;
          end
        end else begin
          data_d  = mem_RD;
          state_d = WRITE;
        end
      end
      WRITE: begin
        mem_A   = dst_q + 32'(idx);
        mem_WD  = (mode_q == M_FILL) ? fill_q : data_q;
        mem_WE  = 1'b1;
        idx_d   = idx_inc;
        state_d = last ? DONE : ((mode_q == M_FILL) ? WRITE : READ);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // Command registers are reset too, so nothing downstream ever sees X after reset.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mode_q     <= M_FILL;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      fill_q     <= '0;
      data_q     <= '0;
      idx        <= '0;
      acc        <= '0;
      err_q      <= 1'b0;
      checksum_q <= '0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      acc    <= acc_d;
      data_q <= data_d;
      err_q  <= err_d;
      if (load_cmd) begin
        mode_q <= mode_in;
        src_q  <= src;
        dst_q  <= dst;
        len_q  <= len;
        fill_q <= fill_val;
      end
      if (load_csum) checksum_q <= acc_d;
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign err      = err_q;
  assign checksum = checksum_q;

endmodule

// File: tb/tb_mem_dma_master.sv
// Self-checking bench for mem_dma_master: a command-level model predicts the per-cycle port trace,
// the memory image and the checksum; directed commands cover the main modes and corner cases.
module tb_mem_dma_master;

  logic        CLK;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] src, dst, fill_val;
  logic [7:0]  len;
  logic        busy, done, err, mem_WE;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic [15:0] checksum;

  mem_dma_master dut (
    .CLK(CLK), .reset(reset), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done), .err(err),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD), .checksum(checksum)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Environment memory: written by the DUT, or by the bench through the poke port.
  bit [31:0]   tb_mem [256];
  logic        poke_en;
  logic [7:0]  poke_addr;
  logic [31:0] poke_data;
  always @(posedge CLK) begin
    if (mem_WE)  tb_mem[mem_A[7:0]] <= mem_WD;
    if (poke_en) tb_mem[poke_addr]  <= poke_data;
  end
  assign mem_RD = tb_mem[mem_A[7:0]];

  // Reference model state.
  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] csum;
  } exp_t;
  exp_t        exp_q[$];
  bit [31:0]   ref_mem [256];
  logic        exp_err;
  logic [15:0] exp_csum;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  // Single compare process: one expected entry per cycle while a command is in flight.
  always @(negedge CLK) begin : compare
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("mem_A",    mem_A,    e.a);
      check("mem_WD",   mem_WD,   e.wd);
      check("mem_WE",   mem_WE,   e.we);
      check("busy",     busy,     e.busy);
      check("done",     done,     e.done);
      check("err",      err,      e.err);
      check("checksum", checksum, e.csum);
    end
  end

  task automatic mem_load(input logic [7:0] a, input logic [31:0] d);
    @(negedge CLK);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    @(negedge CLK);
    poke_en   = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic check_mem_image();
    int bad = -1;
    for (int k = 0; k < 256; k++)
      if (tb_mem[k] !== ref_mem[k] && bad < 0) bad = k;
    check("mem_image_first_bad_idx", bad, 32'hFFFF_FFFF);
  endtask

  // Builds the expected trace of a command from the operation rules, issues it, and
  // optionally pulses start again at cycle poke_at (which must be ignored).
  task automatic run_cmd(input logic [1:0] m, input logic [31:0] s, input logic [31:0] d,
                         input logic [7:0] l, input logic [31:0] f,
                         input int exp_done_at, input int poke_at);
    exp_t        tr[$];
    exp_t        e;
    logic        err_n;
    logic [15:0] acc;
    logic [31:0] w, ad;
    int          done_seen;
    err_n = (m == 2'b11);
`ifdef MEM_DMA_BOUNDS_CHECK_EN
    if ((m == 2'b00 || m == 2'b01) && ({1'b0, d} + 33'(l) > 33'd100)) err_n = 1'b1;
    if ((m == 2'b01 || m == 2'b10) && ({1'b0, s} + 33'(l) > 33'd100)) err_n = 1'b1;
`endif
    e = '{a: 32'h0, wd: 32'h0, we: 1'b0, busy: 1'b1, done: 1'b0, err: 1'b0, csum: exp_csum};
    acc = '0;
    if (!err_n) begin
      for (int i = 0; i < int'(l); i++) begin
        if (m == 2'b00) begin
          ad = d + 32'(i);
          tr.push_back('{ad, f, 1'b1, 1'b1, 1'b0, 1'b0, exp_csum});
          ref_mem[ad[7:0]] = f;
        end else begin
          ad = s + 32'(i);
          w  = ref_mem[ad[7:0]];
          tr.push_back('{ad, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, exp_csum});
          if (m == 2'b01) begin
            ad = d + 32'(i);
            tr.push_back('{ad, w, 1'b1, 1'b1, 1'b0, 1'b0, exp_csum});
            ref_mem[ad[7:0]] = w;
          end else begin
            acc = acc + w[15:0] + w[31:16];
          end
        end
      end
    end
    if (m == 2'b10) exp_csum = acc;
    exp_err = err_n;
    e.done = 1'b1; e.err = exp_err; e.csum = exp_csum;
    tr.push_back(e);
    e.busy = 1'b0; e.done = 1'b0;
    tr.push_back(e);

    @(negedge CLK);
    start = 1'b1; mode = m; src = s; dst = d; len = l; fill_val = f;
    @(posedge CLK);
    #1;
    start = 1'b0; mode = 2'b11; src = '1; dst = '1; len = '1; fill_val = 32'hDEAD_BEEF;
    foreach (tr[k]) exp_q.push_back(tr[k]);
    done_seen = 0;
    for (int c = 1; c <= tr.size(); c++) begin
      @(negedge CLK);
      if (done && done_seen == 0) done_seen = c;
      start = (c == poke_at);
    end
    start = 1'b0;
    check("done_cycle", done_seen, exp_done_at);
    check_mem_image();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; start = 1'b0; mode = '0; src = '0; dst = '0; len = '0; fill_val = '0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    exp_err = 1'b0; exp_csum = '0;
    repeat (2) @(negedge CLK);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_we", mem_WE, 0);
    check("rst_A", mem_A, 0);
    check("rst_WD", mem_WD, 0);
    check("rst_checksum", checksum, 0);
    reset = 1'b1;

    mem_load(8'd0, 32'd1);
    mem_load(8'd1, 32'd2);
    mem_load(8'd2, 32'd3);
    mem_load(8'd41, 32'hDEAD_0041);

    // Fill: 4 writes to 10..13, done in cycle 5.
    run_cmd(2'b00, 32'd0, 32'd10, 8'd4, 32'hA5A5_0001, 5, 0);
    for (int k = 10; k <= 13; k++) check("fill_word", tb_mem[k], 32'hA5A5_0001);

    // Copy 0..2 -> 20..22, done in cycle 7.
    run_cmd(2'b01, 32'd0, 32'd20, 8'd3, 32'h0, 7, 0);
    check("copy_w20", tb_mem[20], 32'd1);
    check("copy_w21", tb_mem[21], 32'd2);
    check("copy_w22", tb_mem[22], 32'd3);
    check("copy_err", err, 0);

    // Checksum with 16-bit wrap: 0x0001+0xFFFF+0x0003+0x0002 = 0x0005.
    mem_load(8'd0, 32'hFFFF_0001);
    mem_load(8'd1, 32'h0002_0003);
    run_cmd(2'b10, 32'd0, 32'd0, 8'd2, 32'h0, 3, 0);
    check("csum_value", checksum, 32'h0005);

    // Degenerate commands.
    run_cmd(2'b00, 32'd0, 32'd50, 8'd0, 32'h1111_1111, 1, 0);
    run_cmd(2'b11, 32'd0, 32'd50, 8'd5, 32'h2222_2222, 1, 0);
    check("illegal_err_held", err, 1);
    check("illegal_csum_held", checksum, 32'h0005);

    // Start pulsed while busy must be ignored.
    run_cmd(2'b00, 32'd0, 32'd60, 8'd4, 32'h1234_5678, 5, 2);
    check("poke_w63", tb_mem[63], 32'h1234_5678);

    // Range past MEMORY_SIZE.
`ifdef MEM_DMA_BOUNDS_CHECK_EN
    run_cmd(2'b00, 32'd0, 32'd98, 8'd3, 32'h0BAD_0098, 1, 0);
    check("bounds_err", err, 1);
    check("bounds_no_write", tb_mem[98], 32'h0);
`else
    run_cmd(2'b00, 32'd0, 32'd98, 8'd3, 32'h0BAD_0098, 4, 0);
    check("bounds_err", err, 0);
    check("bounds_w100", tb_mem[100], 32'h0BAD_0098);
`endif

    // Reset during the second WRITE of a len=4 copy into 40..43.
    @(negedge CLK);
    start = 1'b1; mode = 2'b01; src = 32'd0; dst = 32'd40; len = 8'd4;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (4) @(negedge CLK);
    check("mid_copy_we", mem_WE, 1);
    check("mid_copy_A", mem_A, 32'd41);
    #2 reset = 1'b0;
    #1;
    check("async_rst_we", mem_WE, 0);
    check("async_rst_A", mem_A, 0);
    check("async_rst_WD", mem_WD, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_checksum", checksum, 0);
    @(posedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    check("rst_first_write_kept", tb_mem[40], 32'hFFFF_0001);
    check("rst_second_write_blocked", tb_mem[41], 32'hDEAD_0041);
    ref_mem[40] = 32'hFFFF_0001;
    exp_err  = 1'b0;
    exp_csum = '0;
    check_mem_image();

    // Normal operation after reset: copy then checksum of the fill pattern.
    run_cmd(2'b01, 32'd20, 32'd70, 8'd2, 32'h0, 5, 0);
    run_cmd(2'b10, 32'd10, 32'd0, 8'd4, 32'h0, 5, 0);
    check("csum_fill_pattern", checksum, 32'h9698);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
